// File: rtl/scan_mem_loader.sv
// scan_mem_loader: serial scan responder that turns MSB-first address/data streams into
// single-cycle SRAM requests, streams read data back out, and gates entry into execution.
module scan_mem_loader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_valid,
  input  logic              scan_in,
  input  logic              scan_data_or_addr,
  input  logic              read_write,
  input  logic              scan_start_exec,
  output logic              scan_out,
  output logic              scan_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              exec_start,
  output logic              exec_active,
  output logic              proto_err
);
  localparam int MW = ADDR_W > DATA_W ? ADDR_W : DATA_W;
  localparam int CW = $clog2(MW) + 1;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, RD_REQ, RD_WAIT, SHOUT, EXEC} state_t;
  state_t r_state, w_state_n;
  logic [ADDR_W-1:0] r_addr, w_addr_n, w_addr_sh, r_mem_addr, w_mem_addr_n;
  logic [DATA_W-1:0] r_data, w_data_n, w_data_sh, r_sout, w_sout_n, r_mem_wdata, w_mem_wdata_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic r_op_wr, w_op_wr_n, r_err, w_err_n, r_se_d, r_exec_start;
  logic w_rise, w_last_a, w_last_d;
  assign w_rise    = scan_start_exec & ~r_se_d;
  assign w_last_a  = r_cnt == CW'(ADDR_W - 1);
  assign w_last_d  = r_cnt == CW'(DATA_W - 1);
  assign w_addr_sh = {r_addr[ADDR_W-2:0], scan_in};
  assign w_data_sh = {r_data[DATA_W-2:0], scan_in};
  always_comb begin
    w_state_n     = r_state;
    w_addr_n      = r_addr;
    w_data_n      = r_data;
    w_sout_n      = r_sout;
    w_cnt_n       = r_cnt;
    w_op_wr_n     = r_op_wr;
    w_err_n       = r_err;
    w_mem_addr_n  = r_mem_addr;
    w_mem_wdata_n = r_mem_wdata;
    case (r_state)
      IDLE: if (scan_valid) begin
        if (scan_data_or_addr) w_err_n = 1'b1;
        else begin
          w_state_n = ADDR;
          w_addr_n  = {{(ADDR_W-1){1'b0}}, scan_in};
          w_data_n  = '0;
          w_cnt_n   = CW'(1);
          w_op_wr_n = read_write;
        end
      end
      ADDR: if (scan_valid) begin
        if (scan_data_or_addr) begin
          w_err_n   = 1'b1;
          w_state_n = IDLE;
        end else begin
          w_addr_n = w_addr_sh;
          w_cnt_n  = w_last_a ? '0 : r_cnt + 1'b1;
          if (w_last_a) begin
            w_state_n    = r_op_wr ? DATA : RD_REQ;
            w_mem_addr_n = r_op_wr ? r_mem_addr : w_addr_sh;
          end
        end
      end
      DATA: if (scan_valid) begin
        if (!scan_data_or_addr) begin
          w_err_n   = 1'b1;
          w_state_n = IDLE;
        end else begin
          w_data_n = w_data_sh;
          w_cnt_n  = w_last_d ? '0 : r_cnt + 1'b1;
          if (w_last_d) begin
            w_state_n     = WRITE;
            w_mem_addr_n  = r_addr;
            w_mem_wdata_n = w_data_sh;
          end
        end
      end
      WRITE: begin
        w_state_n = IDLE;
        w_err_n   = r_err | scan_valid;
      end
      RD_REQ: begin
        w_state_n = scan_valid ? IDLE : RD_WAIT;
        w_err_n   = r_err | scan_valid;
      end
      RD_WAIT: begin
        w_state_n = scan_valid ? IDLE : SHOUT;
        w_err_n   = r_err | scan_valid;
        w_sout_n  = scan_valid ? r_sout : mem_rdata;
        w_cnt_n   = '0;
      end
      SHOUT: if (scan_valid) begin
        if (!scan_data_or_addr) begin
          w_err_n   = 1'b1;
          w_state_n = IDLE;
        end else begin
          w_sout_n  = {r_sout[DATA_W-2:0], 1'b0};
          w_cnt_n   = w_last_d ? '0 : r_cnt + 1'b1;
          w_state_n = w_last_d ? IDLE : SHOUT;
        end
      end
      EXEC: w_state_n = scan_start_exec ? EXEC : IDLE;
      default: w_state_n = IDLE;
    endcase
    // A rising exec request overrides whatever the transaction was about to do
    if (w_rise && r_state != EXEC) begin
      w_state_n     = EXEC;
      w_err_n       = r_err | (r_state != IDLE);
      w_sout_n      = r_sout;
      w_mem_addr_n  = r_mem_addr;
      w_mem_wdata_n = r_mem_wdata;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_data       <= '0;
      r_sout       <= '0;
      r_cnt        <= '0;
      r_op_wr      <= 1'b0;
      r_err        <= 1'b0;
      r_se_d       <= 1'b0;
      r_exec_start <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_state      <= w_state_n;
      r_addr       <= w_addr_n;
      r_data       <= w_data_n;
      r_sout       <= w_sout_n;
      r_cnt        <= w_cnt_n;
      r_op_wr      <= w_op_wr_n;
      r_err        <= w_err_n;
      r_se_d       <= scan_start_exec;
      r_exec_start <= (w_state_n == EXEC) && (r_state != EXEC);
      r_mem_addr   <= w_mem_addr_n;
      r_mem_wdata  <= w_mem_wdata_n;
    end
  end
  assign scan_out    = r_sout[DATA_W-1];
  assign scan_ready  = r_state == IDLE || r_state == ADDR || r_state == DATA || r_state == SHOUT;
  assign mem_req     = r_state == WRITE || r_state == RD_REQ;
  assign mem_we      = r_state == WRITE;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign exec_start  = r_exec_start;
  assign exec_active = r_state == EXEC;
  assign proto_err   = r_err;
endmodule

// File: tb/tb_scan_mem_loader.sv
// tb_scan_mem_loader: directed scan transactions with a queue scoreboard for memory
// requests and read-back bits, plus inline checks of handshake timing and error/exec behaviour.
module tb_scan_mem_loader;
  logic clk, reset, scan_valid, scan_in, scan_data_or_addr, read_write, scan_start_exec;
  logic scan_out, scan_ready, mem_req, mem_we, exec_start, exec_active, proto_err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  typedef struct {logic we; logic [15:0] addr; logic [15:0] data;} op_t;
  op_t q_mem[$];
  logic q_bit[$];
  logic rd_phase;
  logic [15:0] mem [logic [15:0]];
  logic [15:0] b_addr [64];
  logic [15:0] b_data [64];
  int n_chk, n_err;

  scan_mem_loader #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .scan_valid(scan_valid), .scan_in(scan_in),
    .scan_data_or_addr(scan_data_or_addr), .read_write(read_write),
    .scan_start_exec(scan_start_exec), .scan_out(scan_out), .scan_ready(scan_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .exec_start(exec_start), .exec_active(exec_active),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rd_mem(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 16'h0;
  endfunction

  // Memory model: writes land on the strobe edge, read data appears one cycle after the strobe
  always @(posedge clk) begin
    if (mem_req && mem_we) mem[mem_addr] = mem_wdata;
    if (mem_req && !mem_we) mem_rdata <= rd_mem(mem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && mem_req) begin
      if (q_mem.size() == 0) chk("unexpected_mem_req", 32'(mem_addr), 32'hFFFFFFFF);
      else begin
        op_t e;
        e = q_mem.pop_front();
        chk("mem_we", 32'(mem_we), 32'(e.we));
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.data));
      end
    end
    if (rd_phase && scan_valid && scan_data_or_addr) begin
      if (q_bit.size() == 0) chk("extra_read_bit", 32'(scan_out), 32'hFFFFFFFF);
      else chk("scan_out_bit", 32'(scan_out), 32'(q_bit.pop_front()));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic sbit(input logic d, input logic b, input logic rw);
    scan_valid = 1'b1; scan_data_or_addr = d; scan_in = b; read_write = rw;
    @(posedge clk); #1;
    scan_valid = 1'b0;
  endtask

  task automatic send_addr(input logic [15:0] a, input logic rw, input int g);
    for (int i = 15; i >= 0; i--) begin
      sbit(1'b0, a[i], rw);
      if (g > 0 && i > 0) idle($urandom_range(0, g));
    end
  endtask

  task automatic send_data(input logic [15:0] d, input int g, input int n);
    for (int i = 15; i >= 16 - n; i--) begin
      sbit(1'b1, d[i], 1'b0);
      if (g > 0 && i > 16 - n) idle($urandom_range(0, g));
    end
  endtask

  task automatic write_txn(input logic [15:0] a, input logic [15:0] d, input int g);
    q_mem.push_back('{1'b1, a, d});
    if (g > 0) idle($urandom_range(0, g));
    send_addr(a, 1'b1, g);
    if (g > 0) idle($urandom_range(0, g));
    send_data(d, g, 16);
  endtask

  task automatic read_txn(input logic [15:0] a, input logic [15:0] exp);
    q_mem.push_back('{1'b0, a, 16'h0});
    send_addr(a, 1'b0, 0);
    chk("rd_ready_low1", 32'(scan_ready), 32'h0);
    idle(1);
    chk("rd_ready_low2", 32'(scan_ready), 32'h0);
    idle(1);
    chk("rd_ready_high", 32'(scan_ready), 32'h1);
    chk("rd_msb", 32'(scan_out), 32'(exp[15]));
    for (int i = 15; i >= 0; i--) q_bit.push_back(exp[i]);
    rd_phase = 1'b1;
    for (int i = 0; i < 16; i++) sbit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    rd_phase = 1'b0;
    chk("rd_bits_consumed", 32'(q_bit.size()), 32'h0);
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    scan_valid = 1'b0; scan_in = 1'b0; scan_data_or_addr = 1'b0;
    read_write = 1'b0; scan_start_exec = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_scan_out"}, 32'(scan_out), 32'h0);
    chk({tag, "_scan_ready"}, 32'(scan_ready), 32'h1);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
    chk({tag, "_exec_start"}, 32'(exec_start), 32'h0);
    chk({tag, "_exec_active"}, 32'(exec_active), 32'h0);
    chk({tag, "_proto_err"}, 32'(proto_err), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0; n_err = 0; rd_phase = 1'b0; mem_rdata = 16'h0;
    mem[16'h0010] = 16'h1234;
    apply_reset();
    chk_reset_outputs("rst");

    write_txn(16'h8004, 16'hBEEF, 0);
    chk("wr_mem_req", 32'(mem_req), 32'h1);
    chk("wr_mem_we", 32'(mem_we), 32'h1);
    chk("wr_ready_low", 32'(scan_ready), 32'h0);
    idle(1);
    chk("wr_req_drop", 32'(mem_req), 32'h0);
    chk("wr_addr_hold", 32'(mem_addr), 32'h8004);
    chk("wr_data_hold", 32'(mem_wdata), 32'hBEEF);
    chk("wr_ready_back", 32'(scan_ready), 32'h1);

    read_txn(16'h0010, 16'h1234);

    for (int i = 0; i < 64; i++) begin
      b_addr[i] = 16'h4000 + 16'(i) * 16'h0101;
      b_data[i] = 16'($urandom);
      write_txn(b_addr[i], b_data[i], 5);
      idle($urandom_range(1, 5));
    end
    idle(2);
    chk("burst_proto_err", 32'(proto_err), 32'h0);
    for (int i = 0; i < 64; i++) chk("burst_mem", 32'(rd_mem(b_addr[i])), 32'(b_data[i]));

    send_addr(16'h00AA, 1'b1, 0);
    send_data(16'hC3C3, 0, 10);
    scan_start_exec = 1'b1;
    idle(1);
    chk("ex_start_pulse", 32'(exec_start), 32'h1);
    chk("ex_active", 32'(exec_active), 32'h1);
    chk("ex_ready_low", 32'(scan_ready), 32'h0);
    chk("ex_proto_err", 32'(proto_err), 32'h1);
    idle(1);
    chk("ex_start_single", 32'(exec_start), 32'h0);
    sbit(1'b0, 1'b1, 1'b1);
    sbit(1'b1, 1'b1, 1'b0);
    chk("ex_ignore_valid", 32'(exec_active), 32'h1);
    scan_start_exec = 1'b0;
    idle(1);
    chk("ex_exit_active", 32'(exec_active), 32'h0);
    chk("ex_exit_ready", 32'(scan_ready), 32'h1);

    apply_reset();
    chk("rst2_proto_err", 32'(proto_err), 32'h0);
    for (int i = 15; i > 8; i--) sbit(1'b0, 1'b1, 1'b1);
    sbit(1'b1, 1'b0, 1'b0);
    chk("err_proto_err", 32'(proto_err), 32'h1);
    chk("err_ready", 32'(scan_ready), 32'h1);
    idle(2);
    write_txn(16'h1357, 16'h2468, 0);
    idle(2);
    chk("err_then_write", 32'(rd_mem(16'h1357)), 32'h2468);
    chk("err_sticky", 32'(proto_err), 32'h1);

    q_mem.push_back('{1'b0, 16'h0010, 16'h0});
    send_addr(16'h0010, 1'b0, 0);
    idle(1);
    chk("rw_ready_low", 32'(scan_ready), 32'h0);
    chk("rw_addr", 32'(mem_addr), 32'h0010);
    reset = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);
    read_txn(16'h0010, 16'h1234);

    idle(5);
    chk("mem_queue_drained", 32'(q_mem.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/scan_mem_loader.md
# scan_mem_loader

DUT-side responder for the serial scan load/readback protocol that preloads CMEM and DMEM before execution. Deserialises MSB-first address and data bit streams into single-cycle SRAM write or read requests, serialises read data back out, and gates entry into execution on `scan_start_exec`. Sits between the chip-level scan pins and the memory arbiter of the CGRA array.

## Interface
- `ADDR_W`, 16, address bits per transaction; the MSB selects CMEM (1) or DMEM (0) downstream.
- `DATA_W`, 16, data bits per transaction.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `scan_valid`  in  1  qualifies `scan_in` for this cycle.
- `scan_in`  in  1  serial bit, MSB first.
- `scan_data_or_addr`  in  1  0 = address phase, 1 = data phase.
- `read_write`  in  1  1 = write, 0 = read; sampled with the first address bit.
- `scan_start_exec`  in  1  level; high = execution mode.
- `scan_out`  out  1  serial read data, MSB first.
- `scan_ready`  out  1  high when the block accepts `scan_valid`.
- `mem_req`  out  1  one-cycle memory strobe.
- `mem_we`  out  1  write enable, valid with `mem_req`.
- `mem_addr`  out  ADDR_W  address, valid with `mem_req`.
- `mem_wdata`  out  DATA_W  write data, valid with `mem_req`.
- `mem_rdata`  in  DATA_W  read data, valid exactly one cycle after a read `mem_req`.
- `exec_start`  out  1  one-cycle pulse on entering execution.
- `exec_active`  out  1  high while in execution mode.
- `proto_err`  out  1  sticky protocol error; cleared only by reset.

## Operation
- States: IDLE, ADDR, DATA, WRITE, RD_REQ, RD_WAIT, SHOUT, EXEC.
- IDLE: on `scan_valid` with `scan_data_or_addr`=0, shift the bit into the address register, latch `read_write` into `op_wr`, set bit count to 1, and go to ADDR.
- ADDR: each valid bit shifts left into the address register. After bit ADDR_W, go to DATA if `op_wr`=1, else RD_REQ.
- DATA (write): count DATA_W valid bits into the data register, then go to WRITE.
- WRITE: assert `mem_req`=1, `mem_we`=1 for one cycle, then return to IDLE.
- RD_REQ: assert `mem_req`=1, `mem_we`=0 for one cycle, then go to RD_WAIT.
- RD_WAIT: capture `mem_rdata` into the output shift register, then go to SHOUT.
- SHOUT: `scan_out` always shows the current MSB. Each valid bit with `scan_data_or_addr`=1 shifts left (`scan_in` is ignored). After DATA_W shifts, return to IDLE.
- `scan_ready`=1 only in IDLE, ADDR, DATA and SHOUT.
- Protocol errors set `proto_err`, drop the transaction with no `mem_req`, and return to IDLE:
  - wrong `scan_data_or_addr` value for the current phase;
  - `scan_valid` while `scan_ready`=0;
  - `scan_valid` in IDLE with `scan_data_or_addr`=1.
- `scan_valid`=0 holds all state and counters; gaps between bits are unlimited.
- Execution:
  - `scan_start_exec` rising while in IDLE: go to EXEC and pulse `exec_start` for one cycle.
  - Rising in any other state: abort the transaction, set `proto_err`, go to EXEC with the pulse. A pending WRITE or RD_REQ is cancelled (no `mem_req`).
- EXEC: `exec_active`=1, `scan_ready`=0, and `scan_valid` is ignored (no error). `scan_start_exec` low returns to IDLE the next cycle.
- Width rules:
  - the bit counter is clog2(max(ADDR_W,DATA_W))+1 bits;
  - the address register is ADDR_W bits and the data register DATA_W bits;
  - no truncation and no wrap. A new transaction clears both shift registers.

## Timing
- Reset values: `scan_out`=0, `scan_ready`=1, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `exec_start`=0, `exec_active`=0, `proto_err`=0. State is IDLE.
- Write: `mem_req` is high in the cycle after the edge that samples the last data bit (latency 1). `scan_ready` is low for that one cycle.
- Read: `mem_req` is high the cycle after the last address bit. `mem_rdata` is captured on the following edge. The MSB is on `scan_out` 3 cycles after the last-address-bit edge, when `scan_ready` rises.
- `scan_out` changes only on a valid shift or on capture. It holds its last value in IDLE.
- `exec_start` is high in the first EXEC cycle, which follows the edge where `scan_start_exec`=1 is first sampled.
- `mem_addr` and `mem_wdata` hold their values after `mem_req` drops.
- Reset asserted mid-transaction forces all outputs to their reset values immediately (asynchronously), with no memory access.

## Test plan
- Write: ADDR_W=16, DATA_W=16; shift addr 0x8004 then data 0xBEEF with `read_write`=1 -> exactly one `mem_req`/`mem_we` cycle with `mem_addr`=0x8004, `mem_wdata`=0xBEEF, the cycle after the last bit.
- Read: shift addr 0x0010 with `read_write`=0; memory model returns 0x1234 -> `scan_ready` low for 2 cycles, then 16 shifts produce 0,0,0,1,0,0,1,0,0,0,1,1,0,1,0,0 on `scan_out`.
- Bursty stimulus: random `scan_valid` gaps (0-5 cycles) across 64 back-to-back writes -> memory model contents match all 64 writes, `proto_err`=0.
- Protocol errors: `scan_data_or_addr` flips to 1 after 7 address bits -> no `mem_req`, `proto_err`=1, state IDLE. A subsequent clean write still completes correctly.
- Execution: `scan_start_exec` rises after 10 data bits -> no `mem_req`, `proto_err`=1, one `exec_start` pulse, `exec_active`=1. `scan_valid` pulses are then ignored. `scan_start_exec` low -> IDLE, `scan_ready`=1.
- Reset: `reset` asserted in RD_WAIT -> all outputs at reset values within the same cycle. A new read after reset returns the correct data.
